// File: rtl/led_sched_pkg.sv
// ============================================================================
// Module   : led_sched_pkg
// Purpose  : Shared state encoding, color field offsets and channel reorder helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_sched_pkg;

    localparam int COLOR_W  = 24;
    localparam int CHAN_W   = 8;
    localparam int RED_LSB  = 16;
    localparam int GRN_LSB  = 8;
    localparam int BLU_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_PRESENT = 3'd2,
        S_LATCH   = 3'd3,
        S_DONE    = 3'd4
    } sched_state_t;

    function automatic logic [COLOR_W-1:0] reorder_color(
        input logic [COLOR_W-1:0] rgb,
        input logic               grb_order
    );
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
        r = rgb[RED_LSB +: CHAN_W];
        g = rgb[GRN_LSB +: CHAN_W];
        b = rgb[BLU_LSB +: CHAN_W];
        return grb_order ? {g, r, b} : rgb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_latch_timer.sv
// ============================================================================
// Module   : led_latch_timer
// Purpose  : Holds active high for exactly LATCH_CYCLES cycles after a start pulse
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_latch_timer #(
    parameter int LATCH_CYCLES = 5000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic start_i,
    output logic active_o,
    output logic done_o
);
    localparam int               CNT_W    = $clog2(LATCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= CNT_LOAD;
            active_q <= 1'b1;
        end else if (active_q) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                active_q <= 1'b0;
            end
        end
    end

    assign active_o = active_q;
    // done marks the final active cycle so the owner leaves LATCH in step with active
    assign done_o   = active_q && (cnt_q == CNT_ONE);

endmodule

`default_nettype wire

// File: rtl/led_refresh_scheduler.sv
// ============================================================================
// Module   : led_refresh_scheduler
// Purpose  : Walks the color buffer once per frame, hands pixels to the serial
//            driver over valid/ready, then times the strand latch gap
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_refresh_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int FBUF_COLOR_WIDTH  = 24,
    parameter int FETCH_MIN_CYCLES  = 2,
    parameter int FETCH_TIMEOUT     = 16,
    parameter int LATCH_CYCLES      = 5000,
    parameter int GRB_ORDER         = 1
) (
    input  logic                         clk_led,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         frame_start,
    input  logic                         color_valid,
    input  logic [FBUF_COLOR_WIDTH-1:0]  color_in,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
    output logic [COLOR_W-1:0]           pixel_data,
    output logic                         pixel_valid,
    input  logic                         pixel_ready,
    output logic                         latch_active,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         fetch_timeout_err,
    output logic [15:0]                  frame_count
);
    localparam int                           WAIT_W   = $clog2(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0]            WAIT_MIN = WAIT_W'(FETCH_MIN_CYCLES);
    localparam logic [WAIT_W-1:0]            WAIT_END = WAIT_W'(FETCH_TIMEOUT - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_IDX = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
    localparam logic                         GRB_SEL  = (GRB_ORDER != 0);

    sched_state_t                 state_q;
    logic [LED_ADDRESS_WIDTH-1:0] led_idx_q;
    logic [WAIT_W-1:0]            wait_cnt_q;
    logic [COLOR_W-1:0]           pixel_data_q;
    logic                         pixel_valid_q;
    logic                         frame_done_q;
    logic                         busy_q;
    logic                         err_q;
    logic [15:0]                  frame_count_q;

    logic w_latch_start;
    logic w_latch_active;
    logic w_latch_last;

    assign w_latch_start = (state_q == S_PRESENT) && pixel_ready && (led_idx_q == LAST_IDX);

    led_latch_timer #(
        .LATCH_CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .clk_i    (clk_led),
        .rst_n    (rst_n),
        .start_i  (w_latch_start),
        .active_o (w_latch_active),
        .done_o   (w_latch_last)
    );

    always_ff @(posedge clk_led or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            led_idx_q     <= '0;
            wait_cnt_q    <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    led_idx_q <= '0;
                    if (enable || frame_start) begin
                        wait_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    // color_valid lags the address by a register, so early samples are stale
                    if ((wait_cnt_q >= WAIT_MIN) && color_valid) begin
                        pixel_data_q  <= reorder_color(color_in[COLOR_W-1:0], GRB_SEL);
                        pixel_valid_q <= 1'b1;
                        state_q       <= S_PRESENT;
                    end else if (wait_cnt_q == WAIT_END) begin
                        pixel_data_q  <= '0;
                        pixel_valid_q <= 1'b1;
                        err_q         <= 1'b1;
                        state_q       <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (pixel_ready) begin
                        pixel_valid_q <= 1'b0;
                        if (led_idx_q == LAST_IDX) begin
                            state_q <= S_LATCH;
                        end else begin
                            led_idx_q  <= led_idx_q + LED_ADDRESS_WIDTH'(1);
                            wait_cnt_q <= '0;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (w_latch_last) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        led_idx_q     <= '0;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign next_led_request_address = led_idx_q;
    assign pixel_data               = pixel_data_q;
    assign pixel_valid              = pixel_valid_q;
    assign latch_active             = w_latch_active;
    assign frame_done               = frame_done_q;
    assign busy                     = busy_q;
    assign fetch_timeout_err        = err_q;
    assign frame_count              = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_led_refresh_scheduler.sv
// ============================================================================
// Module   : tb_led_refresh_scheduler
// Purpose  : Scoreboard bench for led_refresh_scheduler on a 4-LED strand
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_refresh_scheduler;

    localparam int NL  = 4;
    localparam int AW  = 10;
    localparam int LAT = 8;

    logic          clk_led = 1'b0;
    logic          rst_n   = 1'b1;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          color_valid;
    logic [23:0]   color_in;
    logic [AW-1:0] address;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic          pixel_ready = 1'b1;
    logic          latch_active;
    logic          frame_done;
    logic          busy;
    logic          fetch_timeout_err;
    logic [15:0]   frame_count;

    led_refresh_scheduler #(
        .NUM_LEDS          (NL),
        .LED_ADDRESS_WIDTH (AW),
        .FBUF_COLOR_WIDTH  (24),
        .FETCH_MIN_CYCLES  (2),
        .FETCH_TIMEOUT     (16),
        .LATCH_CYCLES      (LAT),
        .GRB_ORDER         (1)
    ) dut (
        .clk_led                  (clk_led),
        .rst_n                    (rst_n),
        .enable                   (enable),
        .frame_start              (frame_start),
        .color_valid              (color_valid),
        .color_in                 (color_in),
        .next_led_request_address (address),
        .pixel_data               (pixel_data),
        .pixel_valid              (pixel_valid),
        .pixel_ready              (pixel_ready),
        .latch_active             (latch_active),
        .frame_done               (frame_done),
        .busy                     (busy),
        .fetch_timeout_err        (fetch_timeout_err),
        .frame_count              (frame_count)
    );

    always #5 clk_led = ~clk_led;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   fetch_len_a [0:NL-1];
    logic stale_mode = 1'b0;
    int   bad_addr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] color_of(input logic [AW-1:0] a);
        case (a)
            10'd0:   return 24'h112233;
            10'd1:   return 24'h445566;
            10'd2:   return 24'h778899;
            10'd3:   return 24'hAABBCC;
            default: return 24'h000000;
        endcase
    endfunction

    // Hand-reordered {G,R,B} expectations for the table above
    function automatic logic [23:0] grb_of(input int i);
        case (i)
            0:       return 24'h221133;
            1:       return 24'h554466;
            2:       return 24'h887799;
            3:       return 24'hBBAACC;
            default: return 24'h000000;
        endcase
    endfunction

    // Buffer model: registered valid arrives 3 cycles after an address change
    initial begin
        int            vcnt;
        logic [AW-1:0] last_addr;
        logic          prev_busy;
        vcnt = 0; last_addr = '0; prev_busy = 1'b0;
        color_valid = 1'b0; color_in = '0;
        forever begin
            @(posedge clk_led); #1;
            if (address != last_addr || (busy && !prev_busy)) vcnt = 0;
            else if (vcnt < 100) vcnt++;
            last_addr   = address;
            prev_busy   = busy;
            color_in    = color_of(address);
            color_valid = stale_mode || (vcnt >= 3 && int'(address) != bad_addr);
        end
    end

    // Monitor: pops the scoreboard on each accepted pixel
    initial begin
        logic        prev_valid, prev_ready, prev_done;
        logic [23:0] prev_data;
        int          fetch_len, lat_len;
        prev_valid = 0; prev_ready = 0; prev_done = 0; prev_data = '0;
        fetch_len = 0; lat_len = 0;
        forever begin
            @(negedge clk_led);
            if (!rst_n) begin
                prev_valid = 0; prev_ready = 0; prev_done = 0;
                fetch_len = 0; lat_len = 0;
                continue;
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", {31'd0, pixel_valid}, 32'd1);
                chk("hold_data", {8'd0, pixel_data}, {8'd0, prev_data});
            end
            if (pixel_valid && !prev_valid) begin
                if (address < NL) fetch_len_a[address] = fetch_len;
                fetch_len = 0;
            end
            if (busy && !pixel_valid && !latch_active && !frame_done) fetch_len++;
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", {22'd0, address}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", {8'd0, pixel_data}, {8'd0, e.data});
                    chk("pix_addr", {22'd0, address}, {22'd0, e.addr});
                end
            end
            if (latch_active) begin
                lat_len++;
            end else if (lat_len != 0) begin
                chk("latch_len", lat_len, LAT);
                lat_len = 0;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_pulse", {31'd0, prev_done}, 32'd0);
            end
            prev_valid = pixel_valid;
            prev_ready = pixel_ready;
            prev_data  = pixel_data;
            prev_done  = frame_done;
        end
    end

    task automatic tick();
        @(posedge clk_led); #1;
    endtask

    task automatic push_frame(input int bad);
        for (int i = 0; i < NL; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.data = (i == bad) ? 24'h0 : grb_of(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin tick(); n++; end
        chk("wait_done", done_cnt, target);
    endtask

    task automatic wait_addr(input logic [AW-1:0] a);
        int n;
        n = 0;
        while (!(busy && address == a) && n < 1000) begin tick(); n++; end
        chk("wait_addr", {22'd0, address}, {22'd0, a});
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!pixel_valid && n < 1000) begin tick(); n++; end
        chk("wait_valid", {31'd0, pixel_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) fetch_len_a[i] = 0;
        #3 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {22'd0, address}, 32'd0);
        chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single frame
        push_frame(-1);
        pulse_start();
        wait_done(1);
        tick();
        chk("f1_count", {16'd0, frame_count}, 32'd1);
        chk("f1_busy", {31'd0, busy}, 32'd0);
        chk("f1_queue", exp_q.size(), 32'd0);

        // Stale color_valid held high
        stale_mode = 1'b1;
        push_frame(-1);
        pulse_start();
        wait_done(2);
        tick();
        for (int i = 0; i < NL; i++) chk("stale_fetch_len", fetch_len_a[i], 32'd3);
        chk("stale_queue", exp_q.size(), 32'd0);
        stale_mode = 1'b0;

        // Backpressure on LED 2
        push_frame(-1);
        pulse_start();
        wait_addr(10'd2);
        pixel_ready = 1'b0;
        wait_valid();
        repeat (5) tick();
        chk("bp_addr", {22'd0, address}, 32'd2);
        pixel_ready = 1'b1;
        wait_done(3);
        tick();
        chk("bp_count", {16'd0, frame_count}, 32'd3);
        chk("bp_queue", exp_q.size(), 32'd0);

        // Continuous mode for three frames
        push_frame(-1); push_frame(-1); push_frame(-1);
        enable = 1'b1;
        wait_done(5);
        wait_addr(10'd1);
        enable = 1'b0;
        wait_done(6);
        repeat (5) tick();
        chk("cont_count", {16'd0, frame_count}, 32'd6);
        chk("cont_frames", done_cnt, 32'd6);
        chk("cont_busy", {31'd0, busy}, 32'd0);
        chk("cont_addr", {22'd0, address}, 32'd0);
        chk("cont_queue", exp_q.size(), 32'd0);

        // Timeout on address 1
        chk("pre_err", {31'd0, fetch_timeout_err}, 32'd0);
        bad_addr = 1;
        push_frame(1);
        pulse_start();
        wait_done(7);
        tick();
        chk("to_fetch_len", fetch_len_a[1], 32'd16);
        chk("to_err", {31'd0, fetch_timeout_err}, 32'd1);
        chk("to_count", {16'd0, frame_count}, 32'd7);
        chk("to_queue", exp_q.size(), 32'd0);
        bad_addr = -1;
        repeat (10) tick();
        chk("to_err_sticky", {31'd0, fetch_timeout_err}, 32'd1);

        // Asynchronous reset while a pixel waits for ready
        push_frame(-1);
        pulse_start();
        wait_addr(10'd2);
        pixel_ready = 1'b0;
        wait_valid();
        @(negedge clk_led); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, pixel_valid}, 32'd0);
        chk("ar_data", {8'd0, pixel_data}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_addr", {22'd0, address}, 32'd0);
        chk("ar_count", {16'd0, frame_count}, 32'd0);
        chk("ar_err", {31'd0, fetch_timeout_err}, 32'd0);
        exp_q.delete();
        @(negedge clk_led); #2;
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        tick();
        push_frame(-1);
        pulse_start();
        wait_done(8);
        tick();
        chk("ar_new_count", {16'd0, frame_count}, 32'd1);
        chk("ar_new_err", {31'd0, fetch_timeout_err}, 32'd0);
        chk("ar_new_queue", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_refresh_scheduler.md
Name: led_refresh_scheduler

Overview:
- Sequences one strand refresh per frame: steps the LED color buffer's read port through addresses 0..NUM_LEDS-1 and waits for the buffer's color_valid on each address.
- Hands each color to the serial LED driver over a valid/ready handshake, then times the strand latch gap.
- Sits in the clk_led domain between led color buffer port B and the LED bit-serial driver.

Parameters:
NUM_LEDS, 50, LEDs per strand (>=1)
LED_ADDRESS_WIDTH, 10, width of buffer address
FBUF_COLOR_WIDTH, 24, stored color {R[23:16],G[15:8],B[7:0]}
FETCH_MIN_CYCLES, 2, minimum cycles in FETCH before color_valid is sampled (>=1)
FETCH_TIMEOUT, 16, FETCH cycles before giving up on color_valid (> FETCH_MIN_CYCLES)
LATCH_CYCLES, 5000, latch-gap length in clk_led cycles (>=1)
GRB_ORDER, 1, 1: pixel_data={G,R,B}; 0: pass through {R,G,B}

Ports:
clk_led  in  1  LED driver clock; sole clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  continuous refresh; start new frame whenever IDLE
frame_start  in  1  one-shot frame request, sampled in IDLE only
color_valid  in  1  buffer: read data stable for current address
color_in  in  FBUF_COLOR_WIDTH  buffer read data
next_led_request_address  out  LED_ADDRESS_WIDTH  buffer read address
pixel_data  out  24  color to driver
pixel_valid  out  1  pixel_data valid
pixel_ready  in  1  driver accepts pixel
latch_active  out  1  high during latch gap; driver holds line low
frame_done  out  1  one-cycle pulse at frame end
busy  out  1  high in any state except IDLE
fetch_timeout_err  out  1  sticky: at least one LED timed out
frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE. All outputs 0. Counters 0. Sticky error cleared. Applies mid-frame: any in-flight pixel is dropped, with no handshake completion.
- IDLE: address=0. Go to FETCH when enable|frame_start, with led_idx=0.
- FETCH:
  - address=led_idx, held stable; wait_cnt increments each cycle from 0.
  - Capture color_in when wait_cnt>=FETCH_MIN_CYCLES and color_valid, then go to PRESENT. This guard rejects a stale color_valid, which is registered and lags an address change.
  - If wait_cnt reaches FETCH_TIMEOUT-1 without capture: capture 0 (black), set fetch_timeout_err, go to PRESENT.
- PRESENT:
  - pixel_valid=1; pixel_data is the registered reordered capture, constant while valid.
  - Address stays held.
  - On pixel_valid&pixel_ready: if led_idx==NUM_LEDS-1, go to LATCH; else led_idx+1, go to FETCH.
  - pixel_valid must not drop before ready.
- Throughput: minimum FETCH_MIN_CYCLES+1 cycles per LED plus handshake wait.
- LATCH: latch_active=1 for exactly LATCH_CYCLES cycles, then go to DONE. pixel_valid=0.
- DONE: one cycle; frame_done=1, frame_count+1, address=0, go to IDLE. Back-to-back frames under enable pass through IDLE, so there is a 1-cycle gap.
- frame_start and enable changes during busy are ignored. Deasserting enable completes the current frame.
- Latch timer: LATCH_CYCLES count uses $clog2(LATCH_CYCLES+1) bits. led_idx compare is exact; no wrap past NUM_LEDS-1.
- NUM_LEDS=1: a single FETCH/PRESENT, then LATCH.

Decomposition:
- Package led_sched_pkg:
  - state enum {IDLE, FETCH, PRESENT, LATCH, DONE}.
  - Function reorder_color(rgb, grb_order).
  - Color field offset localparams.
- One sub-module, led_latch_timer: load/start, count LATCH_CYCLES, done pulse, async active-low reset.

Test Plan:
Common configuration: NUM_LEDS=4, FETCH_MIN_CYCLES=2, FETCH_TIMEOUT=16, LATCH_CYCLES=8, GRB_ORDER=1.
- Single frame: frame_start pulse; buffer model asserts color_valid 3 cycles after each address change; colors 0x112233 for address 0, 0x445566 for 1, and so on; pixel_ready tied 1. -> addresses 0,1,2,3 in order; pixel_data 0x221133, 0x554466, ...; latch_active high exactly 8 cycles; one frame_done pulse; frame_count=1; busy low after.
- Stale valid: color_valid held 1 continuously. -> capture never earlier than 2 cycles after address change; 4 pixels accepted.
- Backpressure: pixel_ready low for 5 cycles on LED 2. -> pixel_valid and pixel_data constant; address held at 2; no skipped or duplicated pixel.
- Timeout: color_valid never asserts for address 1. -> after 16 FETCH cycles pixel_data=0; fetch_timeout_err=1 and stays 1; frame still completes.
- Continuous mode: enable=1 for 3 frames, then deassert during LED 1 of frame 3. -> frame_count reaches 3; frame 3 completes; then IDLE with address 0.
- Async reset mid-PRESENT: rst_n low for 1 cycle mid-handshake. -> outputs 0 immediately, with no clock edge required; frame_count=0; error cleared; a new frame_start works.
